// File: rtl/c499_mon_pkg.sv
// Shared constants and state encoding for the c499 response monitor.
// The bench imports the same MISR constants for its golden signature.
package c499_mon_pkg;

  localparam int          DATA_W    = 32;
  localparam int          CNT_W     = 16;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'h0000_0000;
  localparam int          ALARM_TH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mon_state_e;

endpackage

// File: rtl/c499_misr.sv
// Multiple-input signature register compacting the suspect c499 response.
// The register shifts left and folds POLY back in whenever bit DATA_W-1 falls out.
module c499_misr #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] POLY   = c499_mon_pkg::MISR_POLY,
  parameter logic [DATA_W-1:0] SEED   = c499_mon_pkg::MISR_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] sig_o
);

  logic [DATA_W-1:0] sig_q;
  logic [DATA_W-1:0] sig_d;
  logic [DATA_W-1:0] shifted;

  // Next signature: a load has priority over a compaction step.
  always_comb begin
    shifted = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? POLY : {DATA_W{1'b0}});
    sig_d   = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = shifted ^ din_i;
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/c499_resp_monitor.sv
// Compares Trojan-inserted and golden c499 outputs per test pattern: signature,
// mismatch count, first-failure capture, sticky per-bit fail mask and alarm.
module c499_resp_monitor #(
  parameter int                DATA_W    = c499_mon_pkg::DATA_W,
  parameter int                CNT_W     = c499_mon_pkg::CNT_W,
  parameter logic [DATA_W-1:0] MISR_POLY = c499_mon_pkg::MISR_POLY,
  parameter logic [DATA_W-1:0] MISR_SEED = c499_mon_pkg::MISR_SEED,
  parameter int                ALARM_TH  = c499_mon_pkg::ALARM_TH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_vec_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] dut_out_i,
  input  logic [DATA_W-1:0] gold_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] misr_sig_o,
  output logic [CNT_W-1:0]  vec_cnt_o,
  output logic [CNT_W-1:0]  mismatch_cnt_o,
  output logic              fail_flag_o,
  output logic [CNT_W-1:0]  first_fail_idx_o,
  output logic [DATA_W-1:0] first_fail_diff_o,
  output logic [DATA_W-1:0] bit_fail_mask_o,
  output logic              alarm_o
);

  import c499_mon_pkg::*;

  mon_state_e        state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]  mm_cnt_q, mm_cnt_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  ffi_q, ffi_d;
  logic [DATA_W-1:0] ffd_q, ffd_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              alarm_q, alarm_d;

  logic              accept;
  logic              start_ok;
  logic [CNT_W-1:0]  vec_inc;
  logic [DATA_W-1:0] diff;

  assign in_ready_o = (state_q == RUN);
  assign accept     = in_valid_i && in_ready_o;
  assign start_ok   = start_i && (state_q != RUN);
  assign vec_inc    = vec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign diff       = dut_out_i ^ gold_out_i;

  // Campaign sequencing; an empty campaign goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = (num_vec_i == {CNT_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (accept && (vec_inc == num_q)) begin
          state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result capture: cleared on an honoured start, updated per accepted vector.
  always_comb begin
    num_d     = num_q;
    vec_cnt_d = vec_cnt_q;
    mm_cnt_d  = mm_cnt_q;
    fail_d    = fail_q;
    ffi_d     = ffi_q;
    ffd_d     = ffd_q;
    mask_d    = mask_q;
    if (start_ok) begin
      num_d     = num_vec_i;
      vec_cnt_d = {CNT_W{1'b0}};
      mm_cnt_d  = {CNT_W{1'b0}};
      fail_d    = 1'b0;
      ffi_d     = {CNT_W{1'b0}};
      ffd_d     = {DATA_W{1'b0}};
      mask_d    = {DATA_W{1'b0}};
    end else if (accept) begin
      vec_cnt_d = vec_inc;
      if (diff != {DATA_W{1'b0}}) begin
        // Saturation only freezes the count; mask and signature keep updating.
        if (mm_cnt_q != {CNT_W{1'b1}}) begin
          mm_cnt_d = mm_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          mm_cnt_d = mm_cnt_q;
        end
        mask_d = mask_q | diff;
        if (!fail_q) begin
          fail_d = 1'b1;
          ffi_d  = vec_cnt_q;
          ffd_d  = diff;
        end else begin
          fail_d = fail_q;
        end
      end else begin
        mm_cnt_d = mm_cnt_q;
      end
    end else begin
      num_d = num_q;
    end
    alarm_d = (mm_cnt_d >= CNT_W'(ALARM_TH));
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      num_q     <= {CNT_W{1'b0}};
      vec_cnt_q <= {CNT_W{1'b0}};
      mm_cnt_q  <= {CNT_W{1'b0}};
      fail_q    <= 1'b0;
      ffi_q     <= {CNT_W{1'b0}};
      ffd_q     <= {DATA_W{1'b0}};
      mask_q    <= {DATA_W{1'b0}};
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      vec_cnt_q <= vec_cnt_d;
      mm_cnt_q  <= mm_cnt_d;
      fail_q    <= fail_d;
      ffi_q     <= ffi_d;
      ffd_q     <= ffd_d;
      mask_q    <= mask_d;
      alarm_q   <= alarm_d;
    end
  end

  c499_misr #(
    .DATA_W (DATA_W),
    .POLY   (MISR_POLY),
    .SEED   (MISR_SEED)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start_ok),
    .en_i   (accept),
    .din_i  (dut_out_i),
    .sig_o  (misr_sig_o)
  );

  assign busy_o            = (state_q == RUN);
  assign done_o            = (state_q == DONE);
  assign vec_cnt_o         = vec_cnt_q;
  assign mismatch_cnt_o    = mm_cnt_q;
  assign fail_flag_o       = fail_q;
  assign first_fail_idx_o  = ffi_q;
  assign first_fail_diff_o = ffd_q;
  assign bit_fail_mask_o   = mask_q;
  assign alarm_o           = alarm_q;

endmodule

// File: tb/tb_c499_resp_monitor.sv
// Randomised scoreboard bench for c499_resp_monitor against a campaign-level reference model.
module tb_c499_resp_monitor;
  import c499_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = 16'd0;
  logic        in_valid = 1'b0;
  logic [31:0] dut_out = 32'd0;
  logic [31:0] gold_out = 32'd0;
  logic        in_ready, busy, done, fail_flag, alarm;
  logic [31:0] misr_sig, first_fail_diff, bit_fail_mask;
  logic [15:0] vec_cnt, mismatch_cnt, first_fail_idx;

  c499_resp_monitor dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_vec_i(num_vec),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .dut_out_i(dut_out),
    .gold_out_i(gold_out), .busy_o(busy), .done_o(done), .misr_sig_o(misr_sig),
    .vec_cnt_o(vec_cnt), .mismatch_cnt_o(mismatch_cnt), .fail_flag_o(fail_flag),
    .first_fail_idx_o(first_fail_idx), .first_fail_diff_o(first_fail_diff),
    .bit_fail_mask_o(bit_fail_mask), .alarm_o(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] misr;
    int          vc;
    int          mm;
    bit          fail;
    int          ffi;
    logic [31:0] ffd;
    logic [31:0] mask;
    bit          alarm;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = running, 2 = done
  int          m_st = 0;
  int          m_num, m_vc, m_mm, m_ffi;
  bit          m_fail;
  logic [31:0] m_misr, m_ffd, m_mask;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  function automatic void model_clear();
    m_num = 0; m_vc = 0; m_mm = 0; m_ffi = 0; m_fail = 1'b0;
    m_misr = MISR_SEED; m_ffd = 32'd0; m_mask = 32'd0;
  endfunction

  function automatic void model_accept(logic [31:0] d, logic [31:0] g);
    logic [31:0] df;
    exp_t e;
    df = d ^ g;
    m_misr = (m_misr << 1) ^ (((m_misr >> 31) != 32'd0) ? MISR_POLY : 32'd0) ^ d;
    if (df != 32'd0) begin
      if (m_mm < 65535) m_mm++;
      m_mask = m_mask | df;
      if (!m_fail) begin
        m_fail = 1'b1;
        m_ffi  = m_vc;
        m_ffd  = df;
      end
    end
    m_vc++;
    e.misr = m_misr; e.vc = m_vc; e.mm = m_mm; e.fail = m_fail;
    e.ffi = m_ffi; e.ffd = m_ffd; e.mask = m_mask; e.alarm = (m_mm >= ALARM_TH);
    sbq.push_back(e);
    if (m_vc == m_num) m_st = 2;
  endfunction

  function automatic void compare_model(string tag);
    chk({tag, ".busy"}, 32'(busy), 32'(m_st == 1));
    chk({tag, ".done"}, 32'(done), 32'(m_st == 2));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_st == 1));
    chk({tag, ".misr_sig"}, misr_sig, m_misr);
    chk({tag, ".vec_cnt"}, 32'(vec_cnt), 32'(m_vc));
    chk({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(m_mm));
    chk({tag, ".fail_flag"}, 32'(fail_flag), 32'(m_fail));
    chk({tag, ".first_fail_idx"}, 32'(first_fail_idx), 32'(m_ffi));
    chk({tag, ".first_fail_diff"}, first_fail_diff, m_ffd);
    chk({tag, ".bit_fail_mask"}, bit_fail_mask, m_mask);
    chk({tag, ".alarm"}, 32'(alarm), 32'(m_mm >= ALARM_TH));
  endfunction

  // Monitor: one cycle after every handshake, pop and compare the expected result.
  task automatic monitor();
    bit   acc;
    exp_t e;
    forever begin
      @(posedge clk);
      acc = in_valid && in_ready && rst_n;
      @(negedge clk);
      if (acc) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_accept", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb.misr_sig", misr_sig, e.misr);
          chk("sb.vec_cnt", 32'(vec_cnt), 32'(e.vc));
          chk("sb.mismatch_cnt", 32'(mismatch_cnt), 32'(e.mm));
          chk("sb.fail_flag", 32'(fail_flag), 32'(e.fail));
          chk("sb.first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
          chk("sb.first_fail_diff", first_fail_diff, e.ffd);
          chk("sb.bit_fail_mask", bit_fail_mask, e.mask);
          chk("sb.alarm", 32'(alarm), 32'(e.alarm));
        end
      end
    end
  endtask

  task automatic send(logic [31:0] d, logic [31:0] g);
    @(negedge clk);
    in_valid = 1'b1; dut_out = d; gold_out = g;
    #1;
    chk("in_ready_at_send", 32'(in_ready), 32'(m_st == 1));
    if (m_st == 1) model_accept(d, g);
    @(posedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; dut_out = $urandom; gold_out = $urandom;
    end
  endtask

  task automatic do_start(int n);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1; num_vec = 16'(n);
    if (m_st != 1) begin
      model_clear();
      m_num = n;
      m_st  = (n == 0) ? 2 : 1;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_all(string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #1 compare_model(tag);
  endtask

  function automatic logic [31:0] rand_diff();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 32'd0;
    if (r == 1) return 32'd1 << $urandom_range(0, 31);
    return $urandom | 32'd1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    int n;
    fork monitor(); join_none
    model_clear();

    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    compare_model("reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send($urandom, $urandom);
    check_all("idle");

    // Clean run
    do_start(2);
    send(32'h1, 32'h1);
    check_all("clean1");
    chk("clean_misr1", misr_sig, 32'h1);
    send(32'h0, 32'h0);
    check_all("clean2");
    chk("clean_misr2", misr_sig, 32'h2);
    chk("clean_done", 32'(done), 32'd1);

    // Trojan payload on vectors 2 and 4
    do_start(5);
    for (int i = 0; i < 5; i++) begin
      g = $urandom;
      send(g ^ ((i == 2) ? 32'h10 : (i == 4) ? 32'h11 : 32'h0), g);
    end
    check_all("trojan");
    chk("trojan_mm", 32'(mismatch_cnt), 32'd2);
    chk("trojan_ffi", 32'(first_fail_idx), 32'd2);
    chk("trojan_ffd", first_fail_diff, 32'h10);
    chk("trojan_mask", bit_fail_mask, 32'h11);
    chk("trojan_alarm", 32'(alarm), 32'd0);

    // Alarm with in_valid toggling
    do_start(6);
    for (int i = 0; i < 6; i++) begin
      g = $urandom;
      send(g ^ ($urandom | 32'd1), g);
      idle(1);
    end
    check_all("alarm");
    chk("alarm_mm", 32'(mismatch_cnt), 32'd6);
    chk("alarm_flag", 32'(alarm), 32'd1);

    // Empty campaign
    do_start(0);
    check_all("nv0");
    chk("nv0_done", 32'(done), 32'd1);
    chk("nv0_vec_cnt", 32'(vec_cnt), 32'd0);

    // Start during RUN is ignored; in_valid in DONE is ignored
    do_start(4);
    for (int i = 0; i < 2; i++) begin g = $urandom; send(g ^ rand_diff(), g); end
    do_start(9);
    for (int i = 0; i < 2; i++) begin g = $urandom; send(g ^ rand_diff(), g); end
    send($urandom, $urandom);
    check_all("restart_ign");
    chk("restart_ign_vec_cnt", 32'(vec_cnt), 32'd4);
    chk("restart_ign_done", 32'(done), 32'd1);

    // Reset mid-campaign
    do_start(5);
    for (int i = 0; i < 3; i++) begin g = $urandom; send(g ^ 32'h4, g); end
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    m_st = 0; model_clear(); sbq.delete();
    #1 compare_model("midreset");
    @(negedge clk) rst_n = 1'b1;
    check_all("midreset_rel");

    // Random campaigns, each restarted from DONE after the first
    for (int c = 0; c < 8; c++) begin
      n = $urandom_range(1, 12);
      do_start(n);
      check_all("rand_start");
      while (m_st == 1) begin
        if ($urandom_range(0, 2) == 0) idle(1);
        g = $urandom;
        send(g ^ rand_diff(), g);
      end
      check_all("rand_end");
    end

    idle(2);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c499_resp_monitor.md
Name: c499_resp_monitor

Overview:
- Sits directly downstream of the c499 benchmark (Trojan-inserted and golden instances) in the detection bench.
- Consumes the 32-bit output vector (N724..N755 packed as bit0..bit31) of both instances for each applied test pattern.
- Compacts the suspect response into a MISR signature, counts mismatching vectors and records the first failure.
- Keeps a sticky per-bit fail mask so a payload such as a flipped N728 (bit4) is localised for the ML feature set.

Parameters:
- DATA_W, 32, width of the c499 output vector.
- CNT_W, 16, width of the vector, mismatch and index counters.
- MISR_POLY, 32'h04C1_1DB7, MISR feedback polynomial (bit31 = tap out).
- MISR_SEED, 32'h0000_0000, signature value loaded on start.
- ALARM_TH, 4, mismatch count at or above which alarm asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a campaign; honoured only in IDLE or DONE.
- num_vec  in  CNT_W  vectors in campaign; sampled on accepted start.
- in_valid  in  1  dut_out/gold_out valid.
- in_ready  out  1  monitor accepts a vector this cycle.
- dut_out  in  DATA_W  Trojan-inserted c499 outputs.
- gold_out  in  DATA_W  golden c499 outputs.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- misr_sig  out  DATA_W  running MISR signature of dut_out.
- vec_cnt  out  CNT_W  vectors accepted this campaign.
- mismatch_cnt  out  CNT_W  vectors with dut_out != gold_out; saturates at all-ones.
- fail_flag  out  1  sticky: at least one mismatch this campaign.
- first_fail_idx  out  CNT_W  vec_cnt value (0-based) of the first mismatch.
- first_fail_diff  out  DATA_W  dut_out ^ gold_out of the first mismatch.
- bit_fail_mask  out  DATA_W  OR of all diffs this campaign.
- alarm  out  1  registered: mismatch_cnt >= ALARM_TH.

Behaviour:
- Reset (async, rst_n = 0):
  - State IDLE.
  - All outputs 0, except misr_sig = MISR_SEED.
  - Reset mid-campaign discards all results; no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start: load num_vec, misr_sig = MISR_SEED, clear all counters, flags, masks and alarm.
    - Next state RUN, or DONE if num_vec == 0.
  - RUN: in_ready = 1 combinationally from state only. Accept occurs when in_valid && in_ready.
  - RUN: when the accept makes vec_cnt == stored num_vec, next state is DONE.
  - DONE: results held stable until the next start; further in_valid is ignored.
  - start during RUN is ignored; the campaign is not restarted.
- Per accepted vector, registered and visible the next cycle:
  - diff = dut_out ^ gold_out.
  - misr_sig <= {misr_sig[DATA_W-2:0],1'b0} ^ (misr_sig[DATA_W-1] ? MISR_POLY : 0) ^ dut_out.
  - vec_cnt <= vec_cnt + 1.
  - If diff != 0:
    - mismatch_cnt increments (saturating).
    - bit_fail_mask |= diff.
    - If fail_flag == 0: first_fail_idx <= vec_cnt (pre-increment), first_fail_diff <= diff, fail_flag <= 1.
  - alarm is recomputed from the updated mismatch_cnt; it is therefore valid in the same cycle as the new count.
- in_valid outside RUN is ignored. in_ready = 0 in IDLE and DONE.
- Latency:
  - done/busy change one cycle after the final accept.
  - All result outputs are final when done first reads 1.
- Width rules:
  - vec_cnt never exceeds num_vec.
  - mismatch_cnt saturation does not stop MISR or mask updates.

Decomposition:
- Shared package c499_mon_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - DATA_W default;
  - MISR_POLY/MISR_SEED constants, so the golden signature generator in the bench uses identical values.
- One sub-module: c499_misr (parameterised DATA_W/POLY/SEED; ports clk, rst_n, load, en, din, sig).
- The top holds the FSM, counters and capture logic.

Test Plan:
- Reset/idle: rst_n low, then high, no start → busy=0, done=0, in_ready=0, misr_sig=0, all counters 0; in_valid pulses ignored.
- Clean run:
  - Stimulus: start, num_vec=2; vectors dut=gold=32'h1, then dut=gold=0.
  - Required: misr_sig=32'h1 then 32'h2; mismatch_cnt=0; fail_flag=0; done=1 one cycle after the 2nd accept.
- Trojan payload:
  - Stimulus: num_vec=5; vector 2 has dut = gold ^ 32'h10; vector 4 has dut = gold ^ 32'h11.
  - Required: mismatch_cnt=2, first_fail_idx=2, first_fail_diff=32'h10, bit_fail_mask=32'h11, alarm=0.
- Alarm/backpressure:
  - Stimulus: num_vec=6, all vectors mismatching, in_valid toggled every other cycle.
  - Required: only valid cycles are counted; alarm rises the cycle mismatch_cnt becomes 4; final mismatch_cnt=6.
- Boundary:
  - start with num_vec=0 → DONE next cycle, vec_cnt=0.
  - start during RUN → ignored, counts continue.
  - rst_n low after 3 of 5 vectors → all cleared, IDLE.
  - New start from DONE → counters cleared and misr_sig=MISR_SEED.
